// File: rtl/mel_frame_sched.sv
// mel_frame_sched: frame-level controller for the mel filterbank engine.
//   Write side: on frame_ready_i, pulse mel_start_o, capture strobed energies
//   (mel_wr_i/mel_idx_i/mel_value_i) into the current write bank, commit on
//   mel_done_i (or abort on timeout), then pulse frame_release_o.
//   Read side: stream each full bank as NUM_FILTERS beats over
//   out_valid_o/out_ready_i with out_idx_o/out_data_o/out_last_o.
//   Status: busy_o (write FSM active), error_o (sticky timeout/bad index),
//   frame_count_o (committed frames, wrapping).
module mel_frame_sched #(
  parameter int NUM_FILTERS    = 40,
  parameter int ENERGY_W       = 9,
  parameter int IDX_W          = 6,
  parameter int TIMEOUT_CYCLES = 16384,
  parameter int CNT_W          = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_ready_i,
  output logic                frame_release_o,
  output logic                mel_start_o,
  input  logic                mel_done_i,
  input  logic                mel_wr_i,
  input  logic [IDX_W-1:0]    mel_idx_i,
  input  logic [ENERGY_W-1:0] mel_value_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [ENERGY_W-1:0] out_data_o,
  output logic [IDX_W-1:0]    out_idx_o,
  output logic                out_last_o,
  output logic                busy_o,
  output logic                error_o,
  output logic [CNT_W-1:0]    frame_count_o
);

  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FILTERS - 1);
  localparam logic [IDX_W-1:0] IDX_LIM  = IDX_W'(NUM_FILTERS);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_COMMIT} state_e;

  state_e                  state_q, state_d;
  logic                    wbank_q, wbank_d, rbank_q, rbank_d;
  logic [IDX_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
  logic [1:0]              full_q, full_d;
  logic [1:0][NUM_FILTERS-1:0] mask_q, mask_d;
  logic                    error_q, error_d;
  logic [CNT_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic [1:0][NUM_FILTERS-1:0][ENERGY_W-1:0] buf_q, buf_d;

  logic wr_ok, wr_bad, rd_xfer, rd_last, bank_free;

  assign out_valid_o   = full_q[rbank_q];
  assign out_idx_o     = rd_ptr_q;
  assign out_last_o    = (rd_ptr_q == IDX_LAST);
  // Slots the engine never wrote in this frame read back as zero.
  assign out_data_o    = (out_valid_o && mask_q[rbank_q][rd_ptr_q]) ?
                         buf_q[rbank_q][rd_ptr_q] : '0;
  assign busy_o        = (state_q != S_IDLE);
  assign error_o       = error_q;
  assign frame_count_o = frame_cnt_q;

  always_comb begin
    state_d         = state_q;
    wbank_d         = wbank_q;
    rbank_d         = rbank_q;
    rd_ptr_d        = rd_ptr_q;
    to_cnt_d        = to_cnt_q;
    full_d          = full_q;
    mask_d          = mask_q;
    error_d         = error_q;
    frame_cnt_d     = frame_cnt_q;
    buf_d           = buf_q;
    mel_start_o     = 1'b0;
    frame_release_o = 1'b0;

    wr_ok   = mel_wr_i && (mel_idx_i < IDX_LIM);
    wr_bad  = mel_wr_i && !(mel_idx_i < IDX_LIM);
    rd_xfer = out_valid_o && out_ready_i;
    rd_last = rd_xfer && (rd_ptr_q == IDX_LAST);
    // A bank drained this cycle counts as free so START can follow at once.
    bank_free = !full_q[wbank_q] || (rd_last && (rbank_q == wbank_q));

    // Read side
    if (rd_xfer) begin
      if (rd_last) begin
        rd_ptr_d        = '0;
        full_d[rbank_q] = 1'b0;
        rbank_d         = ~rbank_q;
      end else begin
        rd_ptr_d = rd_ptr_q + IDX_W'(1);
      end
    end

    // Write side
    case (state_q)
      S_IDLE: begin
        if (frame_ready_i && bank_free) state_d = S_START;
      end
      S_START: begin
        mel_start_o     = 1'b1;
        mask_d[wbank_q] = '0;
        to_cnt_d        = '0;
        state_d         = S_RUN;
      end
      S_RUN: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (mel_done_i) begin
          state_d = S_COMMIT;
        end else if (to_cnt_q == TO_LAST) begin
          error_d         = 1'b1;
          frame_release_o = 1'b1;
          state_d         = S_IDLE;
        end
      end
      S_COMMIT: begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
        frame_cnt_d     = frame_cnt_q + CNT_W'(1);
        frame_release_o = 1'b1;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Energy capture applies after the START mask clear so a strobe in
    // the START cycle is kept.
    if (state_q == S_START || state_q == S_RUN) begin
      if (wr_ok) begin
        buf_d[wbank_q][mel_idx_i]  = mel_value_i;
        mask_d[wbank_q][mel_idx_i] = 1'b1;
      end
      if (wr_bad) error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      rd_ptr_q    <= '0;
      to_cnt_q    <= '0;
      full_q      <= '0;
      mask_q      <= '0;
      error_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      rd_ptr_q    <= rd_ptr_d;
      to_cnt_q    <= to_cnt_d;
      full_q      <= full_d;
      mask_q      <= mask_d;
      error_q     <= error_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Energy storage needs no reset: the written masks qualify every read.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_mel_frame_sched.sv
module tb_mel_frame_sched;
  localparam int NF = 40;
  localparam int EW = 9;
  localparam int IW = 6;
  localparam int TO = 64;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_ready, frame_release, mel_start, mel_done, mel_wr;
  logic [IW-1:0] mel_idx;
  logic [EW-1:0] mel_value;
  logic          out_valid, out_ready, out_last, busy, error;
  logic [EW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic [CW-1:0] frame_count;

  int tests = 0;
  int fails = 0;

  mel_frame_sched #(.NUM_FILTERS(NF), .ENERGY_W(EW), .IDX_W(IW),
                    .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .frame_ready_i(frame_ready), .frame_release_o(frame_release),
    .mel_start_o(mel_start), .mel_done_i(mel_done),
    .mel_wr_i(mel_wr), .mel_idx_i(mel_idx), .mel_value_i(mel_value),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_idx_o(out_idx), .out_last_o(out_last),
    .busy_o(busy), .error_o(error), .frame_count_o(frame_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // From IDLE: raise frame_ready, see START, return in the first RUN cycle.
  task automatic start_frame;
    frame_ready = 1'b1;
    #1;
    chk("idle_no_start", 32'(mel_start), 0);
    tick;
    #1;
    chk("start_pulse", 32'(mel_start), 1);
    chk("start_busy", 32'(busy), 1);
    frame_ready = 1'b0;
    tick;
  endtask

  // In RUN: write idx 0..nw-1 with base+idx, optional bad index, then done.
  // Returns in the IDLE cycle after COMMIT.
  task automatic body(input int base, input int nw, input bit bad);
    for (int i = 0; i < nw; i++) begin
      mel_wr = 1'b1; mel_idx = IW'(i); mel_value = EW'(base + i);
      tick;
    end
    if (bad) begin
      #1;
      chk("err_before_bad", 32'(error), 0);
      mel_wr = 1'b1; mel_idx = 6'd45; mel_value = 9'd7;
      tick;
      mel_wr = 1'b0;
      #1;
      chk("bad_idx_err", 32'(error), 1);
    end
    mel_wr = 1'b0; mel_done = 1'b1;
    #1;
    chk("no_release_in_run", 32'(frame_release), 0);
    tick;
    mel_done = 1'b0;
    #1;
    chk("release_after_done", 32'(frame_release), 1);
    tick;
    #1;
    chk("release_one_cycle", 32'(frame_release), 0);
  endtask

  task automatic drain(input int base, input bit miss39);
    out_ready = 1'b1;
    for (int i = 0; i < NF; i++) begin
      #1;
      chk("drain_valid", 32'(out_valid), 1);
      chk("drain_idx", 32'(out_idx), 32'(i));
      chk("drain_data", 32'(out_data), (miss39 && i == NF-1) ? 0 : 32'(base + i));
      chk("drain_last", 32'(out_last), (i == NF-1) ? 1 : 0);
      tick;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; frame_ready = 1'b0; mel_done = 1'b0; mel_wr = 1'b0;
    mel_idx = '0; mel_value = '0; out_ready = 1'b0;
    tick; tick;
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_count", 32'(frame_count), 0);
    chk("rst_start", 32'(mel_start), 0);
    chk("rst_release", 32'(frame_release), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_last", 32'(out_last), 0);

    // 1: single frame
    start_frame;
    #1;
    chk("t1_no_second_start", 32'(mel_start), 0);
    chk("t1_valid_in_run", 32'(out_valid), 0);
    body(100, NF, 1'b0);
    chk("t1_valid_t2", 32'(out_valid), 1);
    chk("t1_count", 32'(frame_count), 1);
    drain(100, 1'b0);
    #1;
    chk("t1_empty", 32'(out_valid), 0);

    // 2: backpressure, ping-pong, start on bank free
    start_frame;
    body(200, NF, 1'b0);
    start_frame;
    body(300, NF, 1'b0);
    frame_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_full_no_start", 32'(mel_start), 0);
      chk("t2_full_not_busy", 32'(busy), 0);
      chk("t2_hold_idx", 32'(out_idx), 0);
      chk("t2_hold_data", 32'(out_data), 200);
      tick;
    end
    chk("t2_count", 32'(frame_count), 3);
    out_ready = 1'b1;
    for (int i = 0; i < NF; i++) begin
      #1;
      chk("t2_drain_data", 32'(out_data), 32'(200 + i));
      chk("t2_no_start_yet", 32'(mel_start), 0);
      tick;
    end
    frame_ready = 1'b0; out_ready = 1'b0;
    #1;
    chk("t2_start_after_free", 32'(mel_start), 1);
    chk("t2_next_bank_valid", 32'(out_valid), 1);
    chk("t2_next_bank_data", 32'(out_data), 300);
    tick;
    body(400, NF, 1'b0);
    chk("t2_count4", 32'(frame_count), 4);
    drain(300, 1'b0);
    drain(400, 1'b0);
    #1;
    chk("t2_empty", 32'(out_valid), 0);

    // 3: timeout 64 cycles after START
    frame_ready = 1'b1;
    tick;
    #1;
    chk("t3_start", 32'(mel_start), 1);
    frame_ready = 1'b0;
    repeat (63) tick;
    chk("t3_no_early_release", 32'(frame_release), 0);
    chk("t3_no_early_error", 32'(error), 0);
    tick;
    chk("t3_release_at_64", 32'(frame_release), 1);
    chk("t3_valid", 32'(out_valid), 0);
    tick;
    chk("t3_error", 32'(error), 1);
    chk("t3_idle", 32'(busy), 0);
    chk("t3_release_one", 32'(frame_release), 0);
    chk("t3_count", 32'(frame_count), 4);
    chk("t3_valid_after", 32'(out_valid), 0);

    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("rst2_error", 32'(error), 0);

    // 4: bad index and missing slot
    start_frame;
    body(50, NF-1, 1'b1);
    drain(50, 1'b1);
    #1;
    chk("t4_error_sticky", 32'(error), 1);
    chk("t4_count", 32'(frame_count), 1);

    // 5: random stalls
    start_frame;
    body(120, NF, 1'b0);
    begin
      int exp_i = 0;
      int cyc = 0;
      while (exp_i < NF && cyc < 400) begin
        out_ready = 1'($urandom_range(0, 1));
        #1;
        chk("t5_valid", 32'(out_valid), 1);
        chk("t5_idx", 32'(out_idx), 32'(exp_i));
        chk("t5_data", 32'(out_data), 32'(120 + exp_i));
        chk("t5_last", 32'(out_last), (exp_i == NF-1) ? 1 : 0);
        if (out_ready) exp_i++;
        tick;
        cyc++;
      end
      chk("t5_beats", 32'(exp_i), NF);
    end
    out_ready = 1'b0;
    #1;
    chk("t5_empty", 32'(out_valid), 0);

    // 6: reset mid-RUN
    start_frame;
    for (int i = 0; i < 10; i++) begin
      mel_wr = 1'b1; mel_idx = IW'(i); mel_value = EW'(i + 1);
      tick;
    end
    mel_wr = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_error", 32'(error), 0);
    chk("t6_count", 32'(frame_count), 0);
    chk("t6_start", 32'(mel_start), 0);
    chk("t6_release", 32'(frame_release), 0);
    chk("t6_data", 32'(out_data), 0);
    chk("t6_idx", 32'(out_idx), 0);
    chk("t6_last", 32'(out_last), 0);
    start_frame;
    body(10, NF, 1'b0);
    chk("t6_count1", 32'(frame_count), 1);
    drain(10, 1'b0);
    #1;
    chk("t6_error_clean", 32'(error), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mel_frame_sched.md
Name: mel_frame_sched

Overview:
Frame-level controller for the mel filterbank engine in the MFCC pipeline.
- Input side: waits for the power-spectrum stage to present a frame, pulses the engine start, and captures the per-filter energies the engine emits into a ping-pong (two-bank) buffer. It then releases the spectrum frame back to the upstream stage.
- Output side: streams each completed bank of NUM_FILTERS energies to the log/DCT stage over a valid/ready handshake.
- Also handles backpressure, engine timeout and error reporting.

Parameters:
NUM_FILTERS, 40, filters per frame; energies per bank
ENERGY_W, 9, energy value width
IDX_W, 6, filter index width
TIMEOUT_CYCLES, 16384, max cycles from start to mel_done_i before abort
CNT_W, 16, committed-frame counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
frame_ready_i  in  1  level: spectrum frame available for mel processing
frame_release_o  out  1  one-cycle pulse: engine finished with current frame (committed or aborted)
mel_start_o  out  1  one-cycle start pulse to mel engine
mel_done_i  in  1  engine finished all filters of frame
mel_wr_i  in  1  energy strobe from engine
mel_idx_i  in  IDX_W  filter index of strobed energy
mel_value_i  in  ENERGY_W  strobed energy value
out_valid_o  out  1  energy available downstream
out_ready_i  in  1  downstream accepts
out_data_o  out  ENERGY_W  energy value
out_idx_o  out  IDX_W  filter index, 0..NUM_FILTERS-1
out_last_o  out  1  high with index NUM_FILTERS-1
busy_o  out  1  write FSM not in IDLE
error_o  out  1  sticky: timeout or out-of-range index
frame_count_o  out  CNT_W  committed frames, wraps modulo 2^CNT_W

Behaviour:
- Reset: all outputs 0; both banks empty; wbank=rbank=0; rd_ptr=0; timeout counter 0; written masks cleared. Reset mid-frame aborts silently, with no release pulse. The mel engine shares the reset.
- Storage: two banks of NUM_FILTERS x ENERGY_W registers. Each bank has a NUM_FILTERS-bit written mask and a full flag.

Write FSM: IDLE, START, RUN, COMMIT.
- IDLE: frame_ready_i sampled. If frame_ready_i=1 and full[wbank]=0, go to START. If both banks are full, stay in IDLE and issue no start.
- START: mel_start_o=1 for exactly this cycle. Clear written mask of wbank and the timeout counter. Go to RUN.
- START/RUN write rule: mel_wr_i with mel_idx_i<NUM_FILTERS writes buf[wbank][idx] and sets its mask bit; a duplicate index overwrites. mel_idx_i>=NUM_FILTERS: write dropped, error_o set.
- RUN: counter increments each cycle. If mel_done_i=1, go to COMMIT. If the counter reaches TIMEOUT_CYCLES-1 without done: set error_o, pulse frame_release_o, go to IDLE. No commit occurs and wbank is unchanged.
- COMMIT: full[wbank]=1, wbank toggles, frame_count_o++, frame_release_o=1 for one cycle, go to IDLE.
- Upstream deasserts frame_ready_i by the cycle after frame_release_o. A still-high frame_ready_i in the following IDLE cycle is treated as a new frame.
- mel_done_i and mel_wr_i are ignored in IDLE and COMMIT. mel_done_i is ignored in START.

Latency:
- frame_ready_i=1 in IDLE at cycle t → mel_start_o at t+1.
- mel_done_i at t → frame_release_o at t+1 → out_valid_o at t+2 if the read side was idle.

Read side:
- out_valid_o = full[rbank]; out_idx_o = rd_ptr.
- out_data_o = buf[rbank][rd_ptr] if its mask bit is set, else 0. Entries the engine never wrote read as 0; error_o is not set for this.
- out_last_o = (rd_ptr==NUM_FILTERS-1).
- Outputs are held stable while out_valid_o && !out_ready_i.
- Transfer on out_valid_o && out_ready_i: rd_ptr++. On last: rd_ptr=0, full[rbank]=0, rbank toggles.
- A commit to one bank and a release of the other bank in the same cycle are independent and both take effect.
- A bank freed on cycle t lets IDLE issue START at t+1.

Other:
- error_o is cleared only by rst.
- busy_o = (state!=IDLE).

Test Plan:
1. Single frame: frame_ready_i=1, engine writes idx 0..39 with value=idx+100, then done, out_ready_i=1 → one mel_start_o pulse; frame_release_o pulses 1 cycle after done; 40 beats of data 100..139, out_last_o only on idx 39; frame_count_o=1.
2. Backpressure/ping-pong: out_ready_i=0, three frames offered → two commits; third frame gets no mel_start_o and busy_o=0. Raise out_ready_i → after bank 0 drains (40 beats), START issues the next cycle.
3. Timeout: TIMEOUT_CYCLES=64, no mel_done_i → error_o=1 and frame_release_o pulse exactly 64 cycles after START; out_valid_o stays 0; frame_count_o unchanged.
4. Bad/missing indices: engine writes idx 0..38 plus idx 45, then done → error_o=1; idx 39 streams data 0; other entries correct.
5. Stall stability: out_ready_i toggled randomly → no beat lost or duplicated; data/idx held while stalled; order 0..39 per frame.
6. Reset mid-RUN after 10 writes → all outputs 0 the next cycle; the next frame runs cleanly with frame_count_o=1.
